// File: rtl/blink_controller.sv
// Blink sequencer: alternates a latched pattern (d0) with a blank (d1) through a
// downstream 2:1 mux for a programmable number of on/off cycles, then pulses done.
module blink_controller #(
    parameter int           N           = 7,
    parameter int           HALF_PERIOD = 25_000_000,
    parameter logic [N-1:0] BLANK       = {N{1'b1}}
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic         stop,
    input  logic [N-1:0] pattern,
    input  logic [3:0]   blinks,
    output logic [N-1:0] d0,
    output logic [N-1:0] d1,
    output logic         sel,
    output logic         busy,
    output logic         done
);

    localparam int CW = $clog2(HALF_PERIOD);
    localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ON   = 2'd1;
    localparam logic [1:0] OFF  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    rem, rem_n;
    logic [N-1:0]  d0_n;

    assign d1 = BLANK;

    // NOTE: every variable gets a default before the case, otherwise a branch that
    // leaves it unassigned infers a latch.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rem_n   = rem;
        d0_n    = d0;
        case (state)
            IDLE: begin
                if (start) begin
                    d0_n    = pattern;
                    rem_n   = blinks;
                    cnt_n   = '0;
                    state_n = (blinks != 4'd0) ? ON : DONE;
                end
            end
            ON: begin
                if (stop) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == LAST) begin
                    cnt_n   = '0;
                    state_n = OFF;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            OFF: begin
                if (stop) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == LAST) begin
                    // rem is the count before this blink finishes, so 1 means last blink
                    cnt_n   = '0;
                    rem_n   = rem - 4'd1;
                    state_n = (rem == 4'd1) ? DONE : ON;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they are glitch-free and
    // line up exactly with the state they describe.
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            rem   <= '0;
            d0    <= '0;
            sel   <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            rem   <= rem_n;
            d0    <= d0_n;
            sel   <= (state_n != ON);
            busy  <= (state_n == ON) || (state_n == OFF);
            done  <= (state_n == DONE);
        end
    end

endmodule

// File: tb/tb_blink_controller.sv
// Self-checking bench for blink_controller: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a timeline model.
module tb_blink_controller;

    localparam int           N  = 7;
    localparam int           HP = 4;
    localparam logic [N-1:0] BL = 7'h7F;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         stop  = 1'b0;
    logic [N-1:0] pattern = '0;
    logic [3:0]   blinks  = '0;
    logic [N-1:0] d0, d1;
    logic         sel, busy, done;

    int checks = 0;
    int errors = 0;

    blink_controller #(.N(N), .HALF_PERIOD(HP), .BLANK(BL)) dut (
        .clock(clock), .reset(reset), .start(start), .stop(stop),
        .pattern(pattern), .blinks(blinks),
        .d0(d0), .d1(d1), .sel(sel), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: a sequence is just a count of elapsed busy cycles; the
    // display is dark during odd half-periods of that timeline.
    bit           m_active = 0;
    bit           m_done   = 0;
    int           m_t      = 0;
    int           m_total  = 0;
    logic [N-1:0] m_d0     = '0;

    always @(posedge clock) begin
        bit prev_done;
        if (reset) begin
            m_active = 0;
            m_done   = 0;
            m_d0     = '0;
        end else begin
            prev_done = m_done;
            m_done    = 0;
            if (m_active) begin
                if (stop) m_active = 0;
                else begin
                    m_t++;
                    if (m_t == m_total) begin
                        m_active = 0;
                        m_done   = 1;
                    end
                end
            end else if (!prev_done && start) begin
                m_d0 = pattern;
                if (blinks == 0) m_done = 1;
                else begin
                    m_active = 1;
                    m_t      = 0;
                    m_total  = int'(blinks) * 2 * HP;
                end
            end
        end
        #1;
        check("model_sel",  32'(sel),  32'(m_active ? ((m_t / HP) % 2 == 1) : 1'b1));
        check("model_busy", 32'(busy), 32'(m_active));
        check("model_done", 32'(done), 32'(m_done));
        check("model_d0",   32'(d0),   32'(m_d0));
        check("model_d1",   32'(d1),   32'(BL));
    end

    task automatic launch(input logic [N-1:0] p, input logic [3:0] b);
        pattern = p;
        blinks  = b;
        start   = 1'b1;
        @(negedge clock);
        start   = 1'b0;
    endtask

    initial begin
        logic [15:0] sel_seq;
        int busy_cnt;
        int done_cnt;

        repeat (2) @(negedge clock);
        reset = 1'b0;
        check("rst_sel",  32'(sel),  32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_d0",   32'(d0),   32'h00);
        check("rst_d1",   32'(d1),   32'h7F);

        // Two blinks: fixed 16-cycle sel pattern, then a single done cycle.
        launch(7'h3F, 4'd2);
        check("two_d0", 32'(d0), 32'h3F);
        busy_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            sel_seq[15-i] = sel;
            busy_cnt += int'(busy);
            @(negedge clock);
        end
        check("two_sel_seq", 32'(sel_seq), 32'h0F0F);
        check("two_busy_cnt", busy_cnt, 16);
        check("two_done", 32'(done), 32'd1);
        check("two_done_busy", 32'(busy), 32'd0);
        @(negedge clock);
        check("two_done_end", 32'(done), 32'd0);

        // Zero blinks: straight to done, never lit.
        launch(7'h11, 4'd0);
        check("zero_done", 32'(done), 32'd1);
        check("zero_busy", 32'(busy), 32'd0);
        check("zero_sel",  32'(sel),  32'd1);
        @(negedge clock);
        check("zero_done_end", 32'(done), 32'd0);
        check("zero_d0", 32'(d0), 32'h11);

        // Re-pulsed start during ON is ignored.
        launch(7'h3F, 4'd3);
        busy_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (i == 1) begin
                pattern = 7'h06;
                start   = 1'b1;
            end else start = 1'b0;
            busy_cnt += int'(busy);
            @(negedge clock);
        end
        start = 1'b0;
        check("restart_busy_cnt", busy_cnt, 24);
        check("restart_d0", 32'(d0), 32'h3F);

        // Stop in the second OFF phase (busy cycle 13).
        launch(7'h2A, 4'd3);
        repeat (13) @(negedge clock);
        check("stop_pre_sel", 32'(sel), 32'd1);
        check("stop_pre_busy", 32'(busy), 32'd1);
        stop = 1'b1;
        @(negedge clock);
        stop = 1'b0;
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_sel",  32'(sel),  32'd1);
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            done_cnt += int'(done);
            @(negedge clock);
        end
        check("stop_no_done", done_cnt, 0);

        // Asynchronous reset between edges during ON.
        launch(7'h3F, 4'd2);
        @(negedge clock);
        check("arst_pre_sel", 32'(sel), 32'd0);
        #2 reset = 1'b1;
        #1;
        check("arst_sel",  32'(sel),  32'd1);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_d0",   32'(d0),   32'h00);
        @(negedge clock);
        reset = 1'b0;
        launch(7'h55, 4'd1);
        repeat (2 * HP) @(negedge clock);
        check("arst_resume_done", 32'(done), 32'd1);
        check("arst_resume_d0", 32'(d0), 32'h55);
        @(negedge clock);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            start   = ($urandom_range(0, 7) == 0);
            stop    = ($urandom_range(0, 15) == 0);
            pattern = N'($urandom);
            blinks  = ($urandom_range(0, 9) == 0) ? 4'(int'($urandom_range(4, 15)))
                                                  : 4'(int'($urandom_range(0, 3)));
            reset   = ($urandom_range(0, 299) == 0);
            @(negedge clock);
        end
        start = 1'b0;
        stop  = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/blink_controller.md
BLINK_CONTROLLER -- requirements
Module: blink_controller

Interface
REQ-001 The block SHALL have parameter N, default 7, giving the width of the display pattern.
REQ-002 The block SHALL have parameter HALF_PERIOD, default 25_000_000, giving the clock cycles per on-phase and per off-phase (legal range at least 2).
REQ-003 The block SHALL have parameter BLANK, default {N{1'b1}}, giving the pattern driven while the display is dark.
REQ-004 clock  in  1  single system clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  request to begin a blink sequence; sampled only in IDLE.
REQ-007 stop  in  1  synchronous abort of a running sequence.
REQ-008 pattern  in  N  pattern to blink; latched when start is accepted.
REQ-009 blinks  in  4  number of on/off cycles to perform (0-15); latched when start is accepted.
REQ-010 d0  out  N  latched pattern, feeding the downstream 2:1 mux data input 0.
REQ-011 d1  out  N  constant BLANK, feeding the downstream mux data input 1.
REQ-012 sel  out  1  mux select: 0 shows d0, 1 shows d1.
REQ-013 busy  out  1  high while in the ON or OFF state.
REQ-014 done  out  1  one-cycle completion pulse.

Function
REQ-015 The FSM SHALL have states IDLE, ON, OFF and DONE; all outputs SHALL be Moore (derived from registers only).
REQ-016 In IDLE, the block SHALL hold sel=1, busy=0 and done=0.
REQ-017 In IDLE with start=1 and blinks!=0, the block SHALL latch pattern and blinks, clear the phase counter, and enter ON on the next edge.
REQ-018 In IDLE with start=1 and blinks==0, the block SHALL latch pattern and enter DONE directly, with no ON phase.
REQ-019 In ON, sel SHALL be 0 and busy 1; the phase counter SHALL increment each cycle, and at count HALF_PERIOD-1 the block SHALL clear the counter and enter OFF.
REQ-020 In OFF, sel SHALL be 1 and busy 1; at count HALF_PERIOD-1 the block SHALL clear the counter and decrement the remaining count.
REQ-021 At the end of OFF, the block SHALL go to DONE if the remaining count was 1, otherwise to ON.
REQ-022 ON and OFF SHALL each last exactly HALF_PERIOD cycles, so a sequence occupies blinks*2*HALF_PERIOD busy cycles followed by exactly one DONE cycle.
REQ-023 In DONE, done SHALL be 1, busy 0 and sel 1; the next state SHALL be IDLE unconditionally.
REQ-024 start asserted in ON, OFF or DONE SHALL be ignored (no re-latch, no restart); start held high SHALL not be accepted until the block is back in IDLE.
REQ-025 stop=1 in ON or OFF SHALL force IDLE on the next edge with no done pulse; stop in IDLE or DONE SHALL have no effect.
REQ-026 If stop and start are both high in IDLE, start SHALL win.
REQ-027 d0 SHALL change only on accepted start and SHALL keep its value after the sequence ends.
REQ-028 d1 SHALL equal BLANK at all times.
REQ-029 The phase counter width SHALL be $clog2(HALF_PERIOD) and the counter SHALL never exceed HALF_PERIOD-1.

Reset
REQ-030 On reset assertion, the block SHALL immediately and asynchronously set state=IDLE, counter=0, remaining=0, d0=0, sel=1, busy=0 and done=0.
REQ-031 Reset asserted mid-sequence SHALL abandon the sequence with no done pulse; operation SHALL resume only on a new start after reset release.

Verification (HALF_PERIOD=4, N=7, BLANK=7'h7F)
REQ-032 reset high, then released -> sel=1, busy=0, done=0, d0=7'h00, d1=7'h7F.
REQ-033 start pulse with pattern=7'h3F, blinks=2 -> d0=7'h3F; sel pattern 0,0,0,0,1,1,1,1,0,0,0,0,1,1,1,1 with busy=1 for 16 cycles; then done=1 for exactly 1 cycle; then IDLE.
REQ-034 start with blinks=0 -> no sel=0 cycle, busy stays 0, done=1 on the cycle after acceptance.
REQ-035 start re-pulsed with pattern=7'h06 during ON of a blinks=3 run -> d0 stays 7'h3F, total busy cycles remain 24.
REQ-036 stop asserted in the second OFF phase -> IDLE next cycle, sel=1, busy=0, no done pulse.
REQ-037 reset asserted asynchronously between clock edges during ON -> sel=1, busy=0 and d0=0 before the next edge; a later start still runs normally.
